// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared types and helpers for the SDF FFT stage controller.
package fft_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_BFLY  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FLUSH = 3'd4
  } fft_stage_state_t;

  localparam logic BF_SEL_FILL = 1'b0;
  localparam logic BF_SEL_BFLY = 1'b1;

  // The delay line has one extra output register on top of its shift stages.
  function automatic int half_beats(input int depth);
    return depth + 1;
  endfunction

endpackage

// File: rtl/fft_beat_cnt.sv
// fft_beat_cnt: modulo-HALF beat counter with load and terminal-count flag.
module fft_beat_cnt #(
  parameter int HALF  = 17,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ld_i,
  input  logic [CNT_W-1:0] ld_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LAST);

  // Load wins over counting; wrap to zero after the last beat of a half.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (tc_o) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: sequencer for one radix-2 SDF FFT stage (mux select,
// twiddle address, input supervision, output beat tagging).
// Optional macro FFT_STAGE_CTRL_STATS_EN adds frame_cnt/err_cnt outputs.
//
// state | meaning
// IDLE  | waiting for a start-of-frame beat
// FILL  | first half of a frame enters the delay line
// BFLY  | second half; butterfly, sum beats go out
// DRAIN | difference beats leave the delay line
// FLUSH | after a protocol error, purge the delay line
module fft_stage_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int DATA_HEIGHT = 16,
  parameter int CNT_W       = $clog2(DATA_HEIGHT + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  output logic             bf_sel,
  output logic [CNT_W-1:0] tw_addr,
  output logic             dout_valid,
  output logic             dout_sof,
  output logic             dout_last,
`ifdef FFT_STAGE_CTRL_STATS_EN
  output logic [15:0]      frame_cnt,
  output logic [15:0]      err_cnt,
`endif
  output logic             err
);

  localparam int HALF = half_beats(DATA_HEIGHT);

  fft_stage_state_t state_q, state_d;
  logic             have_prev_q, have_prev_d;
  logic             dout_valid_q, dout_valid_d;
  logic             dout_sof_q, dout_sof_d;
  logic             dout_last_q, dout_last_d;
  logic             err_q, err_d;
  logic             cnt_ld;
  logic [CNT_W-1:0] cnt_ld_val;
  logic [CNT_W-1:0] cnt;
  logic             cnt_tc;
  logic             beat_ok;

  fft_beat_cnt #(
    .HALF  (HALF),
    .CNT_W (CNT_W)
  ) u_beat_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .ld_i     (cnt_ld),
    .ld_val_i (cnt_ld_val),
    .cnt_o    (cnt),
    .tc_o     (cnt_tc)
  );

  // A mid-frame beat must be present and must not carry a start marker.
  assign beat_ok = in_valid & ~in_sof;

  // Next state, counter control, steering decode and next output tags.
  always_comb begin
    state_d      = state_q;
    have_prev_d  = have_prev_q;
    cnt_ld       = 1'b0;
    cnt_ld_val   = '0;
    dout_valid_d = 1'b0;
    dout_sof_d   = 1'b0;
    dout_last_d  = 1'b0;
    err_d        = 1'b0;
    in_ready     = 1'b0;
    bf_sel       = BF_SEL_FILL;
    tw_addr      = '0;
    case (state_q)
      ST_IDLE: begin
        in_ready    = 1'b1;
        cnt_ld      = 1'b1;
        have_prev_d = 1'b0;
        if (in_valid) begin
          if (in_sof) begin
            // Beat 0 is taken here, so FILL starts at beat 1.
            state_d    = ST_FILL;
            cnt_ld_val = CNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        in_ready     = 1'b1;
        dout_valid_d = have_prev_q;
        dout_last_d  = have_prev_q & cnt_tc;
        if (!beat_ok) begin
          state_d = ST_FLUSH;
          cnt_ld  = 1'b1;
          err_d   = 1'b1;
        end else if (cnt_tc) begin
          state_d = ST_BFLY;
          cnt_ld  = 1'b1;
        end
      end
      ST_BFLY: begin
        in_ready = 1'b1;
        bf_sel   = BF_SEL_BFLY;
        tw_addr  = cnt;
        if (!beat_ok) begin
          state_d = ST_FLUSH;
          cnt_ld  = 1'b1;
          err_d   = 1'b1;
        end else begin
          dout_valid_d = 1'b1;
          dout_sof_d   = (cnt == '0);
          if (cnt_tc) begin
            state_d = ST_DRAIN;
            cnt_ld  = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        in_ready     = (cnt == '0);
        dout_valid_d = 1'b1;
        dout_last_d  = cnt_tc;
        if ((cnt == '0) && in_valid && in_sof) begin
          // Back-to-back frame: remaining differences drain during FILL.
          state_d     = ST_FILL;
          cnt_ld      = 1'b1;
          cnt_ld_val  = CNT_W'(1);
          have_prev_d = 1'b1;
        end else if (cnt_tc) begin
          state_d = ST_IDLE;
          cnt_ld  = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (cnt_tc) begin
          state_d = ST_IDLE;
          cnt_ld  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_ld  = 1'b1;
      end
    endcase
  end

  // State and registered output tags, aligned with the datapath output register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      have_prev_q  <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_sof_q   <= 1'b0;
      dout_last_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      have_prev_q  <= have_prev_d;
      dout_valid_q <= dout_valid_d;
      dout_sof_q   <= dout_sof_d;
      dout_last_q  <= dout_last_d;
      err_q        <= err_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_sof   = dout_sof_q;
  assign dout_last  = dout_last_q;
  assign err        = err_q;

`ifdef FFT_STAGE_CTRL_STATS_EN
  logic [15:0] frame_cnt_q, err_cnt_q;

  // Saturating counts of completed output frames and protocol errors.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (dout_last_q && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (err_q && (err_cnt_q != 16'hFFFF))         err_cnt_q   <= err_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule
